// File: rtl/rv_ecc_scrubber.sv
// Background SECDED scrubber: walks the array through a low-priority memory port,
// writes back single-bit corrections and logs double-bit errors.

module rvecc_decode (
  input  logic        en,
  input  logic [31:0] din,
  input  logic [6:0]  ecc_in,
  input  logic        sed_ded,
  output logic [31:0] dout,
  output logic [6:0]  ecc_out,
  output logic        single_ecc_error,
  output logic        double_ecc_error
);
  logic [6:0]  ecc_check;
  logic [38:0] error_mask;
  logic [38:0] din_plus_parity;
  logic [38:0] dout_plus_parity;

  assign ecc_check[0] = ecc_in[0]^din[0]^din[1]^din[3]^din[4]^din[6]^din[8]^din[10]^din[11]^din[13]^din[15]^din[17]^din[19]^din[21]^din[23]^din[25]^din[26]^din[28]^din[30];
  assign ecc_check[1] = ecc_in[1]^din[0]^din[2]^din[3]^din[5]^din[6]^din[9]^din[10]^din[12]^din[13]^din[16]^din[17]^din[20]^din[21]^din[24]^din[25]^din[27]^din[28]^din[31];
  assign ecc_check[2] = ecc_in[2]^din[1]^din[2]^din[3]^din[7]^din[8]^din[9]^din[10]^din[14]^din[15]^din[16]^din[17]^din[22]^din[23]^din[24]^din[25]^din[29]^din[30]^din[31];
  assign ecc_check[3] = ecc_in[3]^din[4]^din[5]^din[6]^din[7]^din[8]^din[9]^din[10]^din[18]^din[19]^din[20]^din[21]^din[22]^din[23]^din[24]^din[25];
  assign ecc_check[4] = ecc_in[4]^din[11]^din[12]^din[13]^din[14]^din[15]^din[16]^din[17]^din[18]^din[19]^din[20]^din[21]^din[22]^din[23]^din[24]^din[25];
  assign ecc_check[5] = ecc_in[5]^din[26]^din[27]^din[28]^din[29]^din[30]^din[31];
  // Overall parity: set means an odd number of flipped bits, i.e. correctable.
  assign ecc_check[6] = ((^din) ^ (^ecc_in)) & ~sed_ded;

  assign single_ecc_error = en & (ecc_check != 7'd0) & ecc_check[6];
  assign double_ecc_error = en & (ecc_check != 7'd0) & ~ecc_check[6];

  always_comb begin
    error_mask = '0;
    for (int i = 1; i < 40; i++) begin
      if (ecc_check[5:0] == 6'(i)) error_mask[i-1] = 1'b1;
    end
  end

  // Hamming codeword order: check bits sit at the power-of-two positions.
  assign din_plus_parity  = {ecc_in[6], din[31:26], ecc_in[5], din[25:11], ecc_in[4], din[10:4],
                             ecc_in[3], din[3:1], ecc_in[2], din[0], ecc_in[1:0]};
  assign dout_plus_parity = single_ecc_error ? (error_mask ^ din_plus_parity) : din_plus_parity;
  assign dout    = {dout_plus_parity[37:32], dout_plus_parity[30:16], dout_plus_parity[14:8],
                    dout_plus_parity[6:4], dout_plus_parity[2]};
  assign ecc_out = {(dout_plus_parity[38] ^ (ecc_check == 7'b1000000)), dout_plus_parity[31],
                    dout_plus_parity[15], dout_plus_parity[7], dout_plus_parity[3], dout_plus_parity[1:0]};
endmodule

module rv_ecc_scrubber #(
  parameter int DEPTH    = 1024,
  parameter int AW       = $clog2(DEPTH),
  parameter int INTERVAL = 64
) (
  input  logic          clk,
  input  logic          rst_l,
  input  logic          en,
  input  logic          clr_counts,
  output logic          mem_req,
  output logic          mem_wen,
  output logic [AW-1:0] mem_addr,
  output logic [38:0]   mem_wdata,
  input  logic          mem_gnt,
  input  logic [38:0]   mem_rdata,
  input  logic          core_wr_valid,
  input  logic [AW-1:0] core_wr_addr,
  output logic          sec_pulse,
  output logic          ded_pulse,
  output logic [AW-1:0] err_addr,
  output logic [15:0]   sec_count,
  output logic [15:0]   ded_count,
  output logic          pass_done
);
  localparam int TW = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;
  localparam logic [TW-1:0] TIMER_LOAD = TW'(INTERVAL - 1);

  typedef enum logic [2:0] {IDLE, WAIT, RD_REQ, RD_DATA, WR_REQ} state_t;

  state_t        state;
  logic [AW-1:0] ptr;
  logic [TW-1:0] timer;
  logic [31:0]   dec_dout;
  logic [6:0]    dec_ecc;
  logic          dec_sec, dec_ded;
  logic          kill, wrap;
  logic [AW-1:0] ptr_nxt;

  rvecc_decode u_dec (
    .en               (1'b1),
    .din              (mem_rdata[31:0]),
    .ecc_in           (mem_rdata[38:32]),
    .sed_ded          (1'b0),
    .dout             (dec_dout),
    .ecc_out          (dec_ecc),
    .single_ecc_error (dec_sec),
    .double_ecc_error (dec_ded)
  );

  // A core write to the word being scrubbed makes our correction stale.
  assign kill    = core_wr_valid & (core_wr_addr == ptr);
  assign wrap    = (ptr == AW'(DEPTH - 1));
  assign ptr_nxt = wrap ? '0 : ptr + AW'(1);

  // Handshake: a request transfers on a cycle with mem_req & mem_gnt; until then
  // mem_wen/mem_addr/mem_wdata hold steady. A kill withdraws a pending write-back.
  assign mem_req  = (state == RD_REQ) | ((state == WR_REQ) & ~kill);
  assign mem_wen  = (state == WR_REQ);
  assign mem_addr = ptr;

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state     <= IDLE;
      ptr       <= '0;
      timer     <= '0;
      mem_wdata <= '0;
      sec_pulse <= 1'b0;
      ded_pulse <= 1'b0;
      err_addr  <= '0;
      sec_count <= '0;
      ded_count <= '0;
      pass_done <= 1'b0;
    end else begin
      sec_pulse <= 1'b0;
      ded_pulse <= 1'b0;
      pass_done <= 1'b0;
      case (state)
        IDLE: begin
          if (en) begin
            timer <= TIMER_LOAD;
            state <= WAIT;
          end
        end
        WAIT: begin
          if (!en) state <= IDLE;
          else if (timer == '0) state <= RD_REQ;
          else timer <= timer - TW'(1);
        end
        RD_REQ: begin
          if (mem_gnt) state <= RD_DATA;
          else if (!en) state <= IDLE;
        end
        RD_DATA: begin
          if (dec_sec) begin
            sec_pulse <= 1'b1;
            err_addr  <= ptr;
            mem_wdata <= {dec_ecc, dec_dout};
          end
          if (dec_ded) begin
            ded_pulse <= 1'b1;
            err_addr  <= ptr;
          end
          if (dec_sec && !kill) begin
            state <= WR_REQ;
          end else begin
            ptr       <= ptr_nxt;
            pass_done <= wrap;
            timer     <= TIMER_LOAD;
            state     <= en ? WAIT : IDLE;
          end
        end
        WR_REQ: begin
          if (kill || mem_gnt) begin
            ptr       <= ptr_nxt;
            pass_done <= wrap;
            timer     <= TIMER_LOAD;
            state     <= en ? WAIT : IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      if (clr_counts) begin
        sec_count <= '0;
        ded_count <= '0;
      end else begin
        if (state == RD_DATA && dec_sec && sec_count != 16'hFFFF) sec_count <= sec_count + 16'd1;
        if (state == RD_DATA && dec_ded && ded_count != 16'hFFFF) ded_count <= ded_count + 16'd1;
      end
    end
  end
endmodule

// File: tb/tb_rv_ecc_scrubber.sv
// Directed bench for rv_ecc_scrubber: 4-word memory model with a 1-cycle read
// latency, stepped through clean, corrected, double-error, stall, kill and enable cases.
module tb_rv_ecc_scrubber;
  localparam int DEPTH    = 4;
  localparam int AW       = 2;
  localparam int INTERVAL = 2;

  logic          clk = 1'b0;
  logic          rst_l, en, clr_counts, mem_gnt, core_wr_valid;
  logic [AW-1:0] core_wr_addr;
  logic [38:0]   mem_rdata = '0;
  logic          mem_req, mem_wen, sec_pulse, ded_pulse, pass_done;
  logic [AW-1:0] mem_addr, err_addr;
  logic [38:0]   mem_wdata;
  logic [15:0]   sec_count, ded_count;

  logic [38:0]   mem [DEPTH];
  int            wr_cnt = 0;
  logic [AW-1:0] wr_addr_last = '0;
  logic [38:0]   wr_data_last = '0;
  int            pd_cnt = 0;
  int            n_pass = 0;
  int            n_checks = 0;

  rv_ecc_scrubber #(.DEPTH(DEPTH), .AW(AW), .INTERVAL(INTERVAL)) dut (
    .clk(clk), .rst_l(rst_l), .en(en), .clr_counts(clr_counts),
    .mem_req(mem_req), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rdata(mem_rdata),
    .core_wr_valid(core_wr_valid), .core_wr_addr(core_wr_addr),
    .sec_pulse(sec_pulse), .ded_pulse(ded_pulse), .err_addr(err_addr),
    .sec_count(sec_count), .ded_count(ded_count), .pass_done(pass_done)
  );

  // clock
  always #5 clk = ~clk;

  // memory model: read data valid the cycle after an accepted read
  always @(posedge clk) begin
    if (mem_req && mem_gnt) begin
      if (mem_wen) begin
        mem[mem_addr] = mem_wdata;
        wr_cnt       <= wr_cnt + 1;
        wr_addr_last <= mem_addr;
        wr_data_last <= mem_wdata;
      end else begin
        mem_rdata <= mem[mem_addr];
      end
    end
    if (pass_done) pd_cnt <= pd_cnt + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic wait_req(input logic wen, output int n);
    n = 0;
    while (!(mem_req === 1'b1 && mem_wen === wen) && n < 50) begin
      step();
      n++;
    end
  endtask

  int  n;
  bit  ok;

  initial begin
    rst_l = 1'b0; en = 1'b0; clr_counts = 1'b0; mem_gnt = 1'b1;
    core_wr_valid = 1'b0; core_wr_addr = '0;
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    repeat (3) step();

    // reset state
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_wen", mem_wen, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_pulses", {sec_pulse, ded_pulse, pass_done}, 0);
    check("rst_err_addr", err_addr, 0);
    check("rst_counts", {sec_count, ded_count}, 0);
    rst_l = 1'b1;
    step();

    // clean pass: a read every INTERVAL+2 cycles
    en = 1'b1;
    wait_req(1'b0, n);
    check("clean_first_lat", n, 3);
    check("clean_addr0", mem_addr, 0);
    for (int a = 1; a < DEPTH; a++) begin
      step();
      wait_req(1'b0, n);
      check("clean_spacing", n, 3);
      check("clean_addr", mem_addr, a);
    end
    step();
    step();
    check("clean_pass_done", pass_done, 1);
    step();
    check("clean_pass_done_once", pd_cnt, 1);
    check("clean_counts", {sec_count, ded_count}, 0);
    check("clean_no_write", wr_cnt, 0);

    // single error at addr 1, double error at addr 2
    mem[1] = 39'h00_0000_0001;
    mem[2] = 39'h00_0000_0003;
    wait_req(1'b0, n);
    check("sec_pre_addr0", mem_addr, 0);
    step();
    wait_req(1'b0, n);
    check("sec_rd_addr", mem_addr, 1);
    step();
    step();
    check("sec_wr_req", {mem_req, mem_wen}, 2'b11);
    check("sec_wr_addr", mem_addr, 1);
    check("sec_wr_data", mem_wdata, 39'h0);
    check("sec_pulse", sec_pulse, 1);
    check("sec_err_addr", err_addr, 1);
    check("sec_count1", sec_count, 1);
    step();
    check("sec_wr_done", wr_cnt, 1);
    check("sec_wr_last", {wr_addr_last, wr_data_last}, {2'd1, 39'h0});
    check("sec_pulse_clear", sec_pulse, 0);

    wait_req(1'b0, n);
    check("ded_rd_addr", mem_addr, 2);
    step();
    step();
    check("ded_pulse", ded_pulse, 1);
    check("ded_err_addr", err_addr, 2);
    check("ded_count1", ded_count, 1);
    check("ded_no_req", mem_req, 0);
    mem[2] = '0;
    step();
    check("ded_no_write", wr_cnt, 1);

    // grant stall on a read, then a kill during write-back
    wait_req(1'b0, n);
    check("pass2_addr3", mem_addr, 3);
    step();
    mem_gnt = 1'b0;
    wait_req(1'b0, n);
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (!(mem_req === 1'b1 && mem_wen === 1'b0 && mem_addr === 2'd0)) ok = 1'b0;
      step();
    end
    check("stall_hold_stable", ok, 1);
    check("stall_addr", mem_addr, 0);
    mem[1] = 39'h00_0000_0001;
    mem_gnt = 1'b1;
    step();
    step();
    wait_req(1'b0, n);
    check("kill_rd_addr", mem_addr, 1);
    step();
    step();
    check("kill_wr_req", {mem_req, mem_wen}, 2'b11);
    core_wr_valid = 1'b1;
    core_wr_addr  = 2'd1;
    #1;
    check("kill_drops_req", mem_req, 0);
    step();
    core_wr_valid = 1'b0;
    check("kill_no_write", wr_cnt, 1);
    check("kill_sec_count", sec_count, 2);
    mem[1] = '0;

    // en drops in WAIT: no request while disabled, pointer retained
    wait_req(1'b0, n);
    check("kill_ptr_adv", mem_addr, 2);
    step();
    step();
    en = 1'b0;
    ok = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      if (mem_req !== 1'b0) ok = 1'b0;
    end
    check("en_off_wait_idle", ok, 1);
    en = 1'b1;
    wait_req(1'b0, n);
    check("en_resume_lat", n, 3);
    check("en_resume_addr", mem_addr, 3);

    // en drops in WR_REQ: the write-back still completes
    mem[0] = 39'h00_0000_0001;
    step();
    step();
    wait_req(1'b0, n);
    check("enwr_rd_addr", mem_addr, 0);
    step();
    step();
    check("enwr_wr_req", {mem_req, mem_wen}, 2'b11);
    en = 1'b0;
    step();
    check("enwr_write_done", wr_cnt, 2);
    check("enwr_write_last", {wr_addr_last, wr_data_last}, {2'd0, 39'h0});
    ok = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (mem_req !== 1'b0) ok = 1'b0;
      step();
    end
    check("enwr_then_idle", ok, 1);
    en = 1'b1;
    wait_req(1'b0, n);
    check("enwr_resume_lat", n, 3);
    check("enwr_resume_addr", mem_addr, 1);

    // saturation of sec_count
    mem[1] = 39'h00_0000_0001;
    mem[2] = 39'h00_0000_0001;
    force dut.sec_count = 16'hFFFE;
    #1;
    release dut.sec_count;
    step();
    step();
    check("sat_reach_ffff", sec_count, 16'hFFFF);
    step();
    wait_req(1'b0, n);
    check("sat_rd_addr", mem_addr, 2);
    step();
    step();
    check("sat_pulse", sec_pulse, 1);
    check("sat_hold_ffff", sec_count, 16'hFFFF);
    step();

    // clr_counts wins over a same-cycle double error
    mem[3] = 39'h00_0000_0003;
    wait_req(1'b0, n);
    check("clr_rd_addr", mem_addr, 3);
    step();
    clr_counts = 1'b1;
    step();
    clr_counts = 1'b0;
    check("clr_ded_pulse", ded_pulse, 1);
    check("clr_ded_count", ded_count, 0);
    check("clr_sec_count", sec_count, 0);
    check("clr_err_addr", err_addr, 3);
    mem[3] = '0;

    // reset during a write-back request aborts it
    mem[0] = 39'h00_0000_0001;
    wait_req(1'b0, n);
    check("rstmid_rd_addr", mem_addr, 0);
    step();
    step();
    check("rstmid_wr_req", {mem_req, mem_wen}, 2'b11);
    rst_l = 1'b0;
    #1;
    check("rstmid_req_drop", {mem_req, mem_wen}, 2'b00);
    step();
    check("rstmid_no_write", wr_cnt, 4);
    check("rstmid_counts", {sec_count, ded_count}, 0);
    rst_l = 1'b1;
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/rv_ecc_scrubber.md
# rv_ecc_scrubber

Background ECC scrubber for a SECDED-protected closely-coupled memory (ICCM/DCCM-style, 32 data + 7 check bits per word). It walks the array one address at a time, reads each word through the shared memory port, and checks it with an internal rvecc_decode instance (en=1, sed_ded=0). Single-bit errors are written back corrected; double-bit errors are counted and logged. It is a low-priority requester behind the memory arbiter: core traffic always wins, and the scrubber only advances on a grant.

## Interface
- DEPTH, 1024: number of words scrubbed, addresses 0..DEPTH-1; must be ≥2.
- AW, $clog2(DEPTH): address width.
- INTERVAL, 64: idle cycles between scrub reads; must be ≥1.

- clk  in  1  clock
- rst_l  in  1  reset, asynchronous, active-low
- en  in  1  scrub enable (level)
- clr_counts  in  1  synchronous clear of sec_count/ded_count
- mem_req  out  1  scrubber requests the memory port
- mem_wen  out  1  1=write, 0=read; meaningful only while mem_req=1
- mem_addr  out  AW  request address (always the scrub pointer)
- mem_wdata  out  39  write data {ecc[6:0], data[31:0]}
- mem_gnt  in  1  arbiter grant; a request is accepted on a cycle with mem_req & mem_gnt
- mem_rdata  in  39  {ecc, data}; valid exactly 1 cycle after an accepted read
- core_wr_valid  in  1  core write to memory this cycle
- core_wr_addr  in  AW  core write address
- sec_pulse  out  1  one-cycle pulse: single error detected
- ded_pulse  out  1  one-cycle pulse: double error detected
- err_addr  out  AW  address of the most recent error of either kind
- sec_count  out  16  saturating single-error count
- ded_count  out  16  saturating double-error count
- pass_done  out  1  one-cycle pulse: pointer wrapped DEPTH-1→0

## Operation
- States: IDLE, WAIT, RD_REQ, RD_DATA, WR_REQ.
- IDLE: outputs idle. When en=1, load timer=INTERVAL-1 and go to WAIT.
- WAIT: timer decrements each cycle. At timer==0, go to RD_REQ. If en=0, go to IDLE immediately.
- RD_REQ: mem_req=1, mem_wen=0. If mem_gnt=1, go to RD_DATA. If en=0 and there is no grant, go to IDLE.
- RD_DATA: decode mem_rdata.
  - Clean: advance the pointer, then WAIT.
  - Double error: ded_count++, err_addr=ptr, advance the pointer, then WAIT.
  - Single error: sec_count++, err_addr=ptr, latch the corrected word {ecc_out, dout} into mem_wdata. Go to WR_REQ, unless a kill applies (core_wr_valid & core_wr_addr==ptr this cycle); then advance the pointer and go to WAIT.
- WR_REQ: mem_req=1, mem_wen=1.
  - A kill in this state drops the request that cycle: no write, advance the pointer, go to WAIT.
  - Otherwise mem_gnt=1 advances the pointer and goes to WAIT.
  - en=0 does not abandon a write-back; the write completes first.
- Leaving RD_DATA or WR_REQ: next state is WAIT (timer reloaded) if en=1, else IDLE.
- Pointer advance: ptr+1; DEPTH-1 wraps to 0 and pulses pass_done the following cycle.
- Counters saturate at 16'hFFFF. clr_counts wins over a same-cycle increment; the pulses still fire.
- sec_pulse, ded_pulse, and the err_addr update are registered: visible the cycle after RD_DATA.
- The pointer is retained across en toggles; only reset clears it.

## Timing
- Reset: state IDLE, ptr=0, timer=0. All outputs 0: mem_req, mem_wen, mem_addr, mem_wdata, pulses, err_addr, both counts, pass_done.
- mem_req, mem_wen, mem_addr, mem_wdata are registered/state-decoded; there is no combinational path from mem_gnt to them.
- With mem_gnt tied to 1, a clean word costs INTERVAL + 2 cycles (WAIT×INTERVAL, RD_REQ, RD_DATA). A corrected word costs INTERVAL + 3.
- Grant stalls extend RD_REQ/WR_REQ indefinitely. mem_addr and mem_wdata stay stable while mem_req=1.
- Reset mid-operation aborts any request immediately with no write.

## Test plan
- Clean pass: DEPTH=4, INTERVAL=2, gnt=1, memory all 39'h0, en=1. Required:
  - reads at addresses 0,1,2,3 every 4 cycles;
  - pass_done pulses once, the cycle after the read of addr 3;
  - counts stay 0.
- Single-error correction: addr 1 holds 39'h00_0000_0001. Required:
  - write to addr 1 with mem_wdata=39'h0 the cycle after RD_DATA;
  - sec_pulse=1, err_addr=1, sec_count=1.
- Double error: addr 2 holds 39'h00_0000_0003. Required:
  - no write;
  - ded_pulse=1, err_addr=2, ded_count=1.
- Arbitration and kill: gnt=0 for 10 cycles in RD_REQ, so the request holds with stable addr. Then, with a single error at addr 1, core_wr_valid with core_wr_addr=1 in WR_REQ. Required: mem_req drops and no write is accepted.
- Enable and saturation:
  - en drops in WAIT → IDLE next cycle;
  - en drops in WR_REQ → the write completes, then IDLE; on resume the pointer continues.
  - Force sec_count=16'hFFFF, then another error → stays 16'hFFFF.
  - clr_counts with a same-cycle error → 0.
